// File: rtl/fetch_pkg.sv
// Shared types and helpers for the LEGv8 fetch front end.
// OPC_B and b_offset serve the FETCH_BTAKEN_EN branch pre-decode.
package fetch_pkg;

  localparam logic [5:0] OPC_B = 6'b000101;

  localparam int PKG_ADDR_W  = 64;
  localparam int PKG_INSTR_W = 32;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0]  pc;
    logic [PKG_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // imm26 -> byte offset: sign-extend, then scale by 4
  function automatic logic [63:0] b_offset(
    input logic [25:0] imm26
  );
    return {{36{imm26[25]}}, imm26, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: imem port, redirect, decode handshake.
// master = fetch_queue side, slave = environment side.
interface fetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);

  logic [ADDR_W-1:0]      startpc;
  logic                   fetch_en;
  logic [ADDR_W-1:0]      imem_addr;
  logic [INSTR_W-1:0]     imem_data;
  logic                   redirect;
  logic [ADDR_W-1:0]      redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_W-1:0]      out_pc;
  logic [INSTR_W-1:0]     out_instr;
  logic [$clog2(DEPTH):0] count;

  modport master (
    input  startpc, fetch_en, imem_data,
    input  redirect, redirect_pc, out_ready,
    output imem_addr, out_valid, out_pc,
    output out_instr, count
  );

  modport slave (
    output startpc, fetch_en, imem_data,
    output redirect, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_pc,
    input  out_instr, count
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head reads as zero when empty.
// A push while full is legal only alongside a pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // entry storage; data needs no reset
  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[wr_ptr] <= din;
  end

  assign valid = (cnt != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/fetch_queue.sv
// LEGv8 fetch front end: fetch PC, imem address, decode FIFO.
// FETCH_BTAKEN_EN: follow unconditional B at fetch time.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 4
) (
  input logic           CLK,
  input logic           reset,
  fetch_queue_if.master fq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] seq_pc;
  logic              push;
  logic              pop;
  logic              vld;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     head;

  assign pop  = vld & fq.out_ready & ~fq.redirect;
  assign push = fq.fetch_en & ~fq.redirect
              & ((cnt < CW'(DEPTH)) | pop);

`ifdef FETCH_BTAKEN_EN
  logic [63:0] boff;
  logic        is_b;
  assign boff   = b_offset(fq.imem_data[25:0]);
  assign is_b   = (fq.imem_data[31:26] == OPC_B);
  assign seq_pc = is_b ? fetch_pc + boff[ADDR_W-1:0]
                       : fetch_pc + ADDR_W'(PC_STEP);
`else
  assign seq_pc = fetch_pc + ADDR_W'(PC_STEP);
`endif

  // next fetch PC: redirect first, then advance on push
  always_comb begin
    pc_next = fetch_pc;
    if (fq.redirect)
      pc_next = fq.redirect_pc;
    else if (push)
      pc_next = seq_pc;
  end

  // fetch PC register
  always_ff @(posedge CLK) begin
    if (reset) fetch_pc <= fq.startpc;
    else       fetch_pc <= pc_next;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .flush (fq.redirect),
    .push  (push),
    .pop   (pop),
    .din   ({fetch_pc, fq.imem_data}),
    .dout  (head),
    .valid (vld),
    .count (cnt)
  );

  assign fq.imem_addr = fetch_pc;
  assign fq.out_valid = vld;
  assign fq.out_pc    = head[EW-1:INSTR_W];
  assign fq.out_instr = head[INSTR_W-1:0];
  assign fq.count     = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stream, stall, redirect,
// reset, PC wrap and B pre-decode (FETCH_BTAKEN_EN aware).
module tb_fetch_queue;

  logic clk = 1'b0;
  logic reset;
  logic bmode;
  int   vectors = 0;
  int   miscompares = 0;

  fetch_queue_if #(
    .ADDR_W(64), .INSTR_W(32), .DEPTH(4)
  ) ifc ();

  fetch_queue #(
    .ADDR_W(64), .INSTR_W(32),
    .DEPTH(4), .PC_STEP(4)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .fq    (ifc.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(
    input logic [63:0] a, input logic bm
  );
    if (bm && a == 64'h100) return {6'b000101, 26'd3};
    return {16'hAA00, a[15:0]};
  endfunction

  always_comb ifc.imem_data = imem_f(ifc.imem_addr, bmode);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [63:0] e;

  initial begin
    bmode = 1'b0;
    reset = 1'b1;
    ifc.startpc     = 64'h100;
    ifc.fetch_en    = 1'b1;
    ifc.out_ready   = 1'b1;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = '0;

    // reset and stream
    tick(); tick();
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_count", 64'(ifc.count), 64'd0);
    chk("rst_pc", ifc.out_pc, 64'd0);
    chk("rst_instr", 64'(ifc.out_instr), 64'd0);
    chk("rst_addr", ifc.imem_addr, 64'h100);
    reset = 1'b0;
    tick();
    chk("s0_valid", 64'(ifc.out_valid), 64'd1);
    chk("s0_pc", ifc.out_pc, 64'h100);
    chk("s0_instr", 64'(ifc.out_instr), 64'hAA000100);
    tick();
    chk("s1_pc", ifc.out_pc, 64'h104);
    tick();
    chk("s2_pc", ifc.out_pc, 64'h108);
    chk("s2_count", 64'(ifc.count), 64'd1);

    // fill and stall
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (5) tick();
    chk("full_count", 64'(ifc.count), 64'd4);
    chk("full_addr", ifc.imem_addr, 64'h110);
    chk("full_pc", ifc.out_pc, 64'h100);
    tick();
    chk("hold_pc", ifc.out_pc, 64'h100);
    chk("hold_addr", ifc.imem_addr, 64'h110);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk("pp_count", 64'(ifc.count), 64'd4);
    chk("pp_pc", ifc.out_pc, 64'h104);
    chk("pp_addr", ifc.imem_addr, 64'h114);

    // redirect flush from count=3
    ifc.out_ready = 1'b1;
    ifc.fetch_en  = 1'b0;
    tick();
    chk("c3_count", 64'(ifc.count), 64'd3);
    chk("c3_pc", ifc.out_pc, 64'h108);
    ifc.fetch_en    = 1'b1;
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 64'h2000;
    tick();
    ifc.redirect = 1'b0;
    chk("rd_count", 64'(ifc.count), 64'd0);
    chk("rd_valid", 64'(ifc.out_valid), 64'd0);
    chk("rd_pc0", ifc.out_pc, 64'd0);
    chk("rd_addr", ifc.imem_addr, 64'h2000);
    tick();
    chk("rd_tgt_pc", ifc.out_pc, 64'h2000);
    chk("rd_tgt_ins", 64'(ifc.out_instr), 64'hAA002000);

    // reset mid-operation beats redirect
    ifc.out_ready = 1'b0;
    tick();
    chk("mid_count", 64'(ifc.count), 64'd2);
    reset           = 1'b1;
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 64'h3000;
    tick();
    chk("mr_count", 64'(ifc.count), 64'd0);
    chk("mr_addr", ifc.imem_addr, 64'h100);
    chk("mr_valid", 64'(ifc.out_valid), 64'd0);
    ifc.redirect = 1'b0;

    // PC wrap and pointer wrap
    ifc.startpc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    chk("w_pc0", ifc.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_ins0", 64'(ifc.out_instr), 64'hAA00FFFC);
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * k);
      chk("w_pc", ifc.out_pc, e);
      chk("w_ins", 64'(ifc.out_instr),
          {48'd0, 16'hAA00, e[15:0]} & 64'hFFFF_FFFF);
    end
    ifc.out_ready = 1'b0;
    repeat (3) tick();
    chk("w_full", 64'(ifc.count), 64'd4);
    ifc.out_ready = 1'b1;
    ifc.fetch_en  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = 64'h18 + 64'(4 * k);
      chk("dr_pc", ifc.out_pc, e);
      chk("dr_ins", 64'(ifc.out_instr),
          {32'd0, 16'hAA00, e[15:0]});
    end
    tick();
    chk("dr_empty", 64'(ifc.out_valid), 64'd0);
    chk("dr_count", 64'(ifc.count), 64'd0);

    // B pre-decode at 0x100
    bmode = 1'b1;
    ifc.startpc  = 64'h100;
    ifc.fetch_en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("b_pc", ifc.out_pc, 64'h100);
    chk("b_ins", 64'(ifc.out_instr), 64'h14000003);
    tick();
`ifdef FETCH_BTAKEN_EN
    chk("b_next", ifc.out_pc, 64'h10C);
`else
    chk("b_next", ifc.out_pc, 64'h104);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
